sequence_detector_ctrl: RTL

- Sequencer for the serial sequence detector: the 1-bit-X / mode-M / Z-output block.
- Latches a parallel test word and a Mealy/Moore mode select.
- Clears the detector, then feeds the word MSB-first on X, one bit per clock.
- Counts detector Z assertions with the timing correction each mode needs; reports completion through a start/busy/done handshake.
- Sits between the system bus / test sequencer and the detector instance.

---
 rtl/sequence_detector_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/sequence_detector_ctrl.sv
// Sequencer for the serial sequence detector: latches a test word and mode, clears the detector,
// shifts the word out MSB-first on X and counts qualified Z assertions with a start/busy/done handshake.
module sequence_detector_ctrl #(
  parameter int WIDTH = 44,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] pattern,
  input  logic             abort,
  input  logic             Z,
  output logic             X,
  output logic             M,
  output logic             det_reset,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] det_count
);

  localparam int BCW = $clog2(WIDTH);
  localparam logic [BCW-1:0]   LAST_BIT = BCW'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BCW-1:0]   bit_q, bit_d;
  logic             m_q, m_d;
  logic             ab_q, ab_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             qual;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      m_q     <= 1'b0;
      ab_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      m_q     <= m_d;
      ab_q    <= ab_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    m_d     = m_q;
    ab_d    = ab_q;
    cnt_d   = cnt_q;
    qual    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d    = pattern;
          m_d     = mode;
          cnt_d   = '0;
          ab_d    = 1'b0;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        if (abort) begin
          ab_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          bit_d   = LAST_BIT;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          ab_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          // Moore Z lags X by one bit, so its first SHIFT sample belongs to no pattern bit
          qual = !m_q || (bit_q != LAST_BIT);
          sr_d = {sr_q[WIDTH-2:0], 1'b0};
          if (bit_q == '0) begin
            state_d = S_DRAIN;
          end else begin
            bit_d = bit_q - 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (abort) begin
          ab_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          qual    = m_q;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (qual && Z && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign X         = (state_q == S_SHIFT) && sr_q[WIDTH-1];
  assign M         = m_q;
  assign det_reset = (state_q == S_CLR);
  assign busy      = (state_q == S_CLR) || (state_q == S_SHIFT) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign aborted   = ab_q;
  assign det_count = cnt_q;

endmodule
